// File: rtl/key_debounce.sv
// key_debounce: per-channel 2-flop sync, debounce counter and 4-state FSM.
// Optional macro KEY_RELEASE_PULSE_EN builds the Key_Release pulse register.
//
// Ports:
//   CLK         rising-edge clock
//   RSTn        async active-low reset
//   Key_Raw     raw button pins (ACTIVE_LOW sets pressed polarity)
//   Key_Level   debounced level, 1 = pressed
//   Key_Press   1-cycle pulse on Key_Level 0->1
//   Key_Release 1-cycle pulse on Key_Level 1->0 (0 unless macro set)
module key_debounce #(
  parameter int          N_KEYS     = 6,
  parameter int          CNT_W      = 20,
  parameter int unsigned CNT_MAX    = 999_999,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [N_KEYS-1:0] Key_Raw,
  output logic [N_KEYS-1:0] Key_Level,
  output logic [N_KEYS-1:0] Key_Press,
  output logic [N_KEYS-1:0] Key_Release
);

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);
  localparam logic [N_KEYS-1:0] LP_IDLE_PIN = {N_KEYS{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } st_t;

  logic [N_KEYS-1:0] r_s1;
  logic [N_KEYS-1:0] r_s2;
  logic [N_KEYS-1:0] w_p;

  // Sync flops reset to the idle pin level so a key held
  // through reset is seen as a fresh press.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_s1 <= LP_IDLE_PIN;
      r_s2 <= LP_IDLE_PIN;
    end else begin
      r_s1 <= Key_Raw;
      r_s2 <= r_s1;
    end
  end

  assign w_p = r_s2 ^ LP_IDLE_PIN;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    st_t              r_st;
    st_t              w_st_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             r_lvl;
    logic             w_lvl_nx;
    logic             r_prs;
    logic             w_prs_nx;
    logic             w_done;
`ifdef KEY_RELEASE_PULSE_EN
    logic             r_rel;
    logic             w_rel_nx;
`endif

    assign w_done = (r_cnt == LP_MAX);

    always_comb begin
      w_st_nx  = r_st;
      w_cnt_nx = r_cnt;
      w_lvl_nx = r_lvl;
      w_prs_nx = 1'b0;
`ifdef KEY_RELEASE_PULSE_EN
      w_rel_nx = 1'b0;
`endif
      unique case (r_st)
        IDLE: begin
          if (w_p[g]) begin
            w_st_nx  = PRESS_WAIT;
            w_cnt_nx = LP_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!w_p[g]) begin
            w_st_nx  = IDLE;
            w_cnt_nx = '0;
          end else if (w_done) begin
            w_st_nx  = PRESSED;
            w_cnt_nx = '0;
            w_lvl_nx = 1'b1;
            w_prs_nx = 1'b1;
          end else begin
            w_cnt_nx = r_cnt + LP_ONE;
          end
        end
        PRESSED: begin
          if (!w_p[g]) begin
            w_st_nx  = RELEASE_WAIT;
            w_cnt_nx = LP_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (w_p[g]) begin
            w_st_nx  = PRESSED;
            w_cnt_nx = '0;
          end else if (w_done) begin
            w_st_nx  = IDLE;
            w_cnt_nx = '0;
            w_lvl_nx = 1'b0;
`ifdef KEY_RELEASE_PULSE_EN
            w_rel_nx = 1'b1;
`endif
          end else begin
            w_cnt_nx = r_cnt + LP_ONE;
          end
        end
        default: begin
          w_st_nx  = IDLE;
          w_cnt_nx = '0;
          w_lvl_nx = 1'b0;
        end
      endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
        r_st  <= IDLE;
        r_cnt <= '0;
        r_lvl <= 1'b0;
        r_prs <= 1'b0;
      end else begin
        r_st  <= w_st_nx;
        r_cnt <= w_cnt_nx;
        r_lvl <= w_lvl_nx;
        r_prs <= w_prs_nx;
      end
    end

    assign Key_Level[g] = r_lvl;
    assign Key_Press[g] = r_prs;

`ifdef KEY_RELEASE_PULSE_EN
    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) r_rel <= 1'b0;
      else       r_rel <= w_rel_nx;
    end
    assign Key_Release[g] = r_rel;
`else
    assign Key_Release[g] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed checks of key_debounce
// with CNT_MAX=15, ACTIVE_LOW=1 (17-cycle latency).
module tb_key_debounce;

  logic       CLK;
  logic       RSTn;
  logic [5:0] Key_Raw;
  logic [5:0] Key_Level;
  logic [5:0] Key_Press;
  logic [5:0] Key_Release;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef KEY_RELEASE_PULSE_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  key_debounce #(
    .N_KEYS    (6),
    .CNT_W     (20),
    .CNT_MAX   (15),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .Key_Raw    (Key_Raw),
    .Key_Level  (Key_Level),
    .Key_Press  (Key_Press),
    .Key_Release(Key_Release)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic test_reset();
    bit bad;
    RSTn    = 1'b0;
    Key_Raw = 6'b111111;
    step(3);
    n_cmp++;
    if ({Key_Level, Key_Press, Key_Release} !== 18'd0) begin
      n_bad++;
      $display("FAIL reset_out: got %b/%b/%b want 0",
               Key_Level, Key_Press, Key_Release);
    end
    RSTn = 1'b1;
    bad  = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if ({Key_Level, Key_Press, Key_Release} !== 18'd0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL reset_idle: output went nonzero, want 0");
    end
  endtask

  task automatic test_press();
    Key_Raw[0] = 1'b0;
    step(17);
    n_cmp++;
    if (Key_Level !== 6'b0 || Key_Press !== 6'b0) begin
      n_bad++;
      $display("FAIL press_early: lvl=%b prs=%b want 0/0",
               Key_Level, Key_Press);
    end
    step(1);
    n_cmp++;
    if (Key_Level !== 6'b000001 || Key_Press !== 6'b000001) begin
      n_bad++;
      $display("FAIL press_edge: lvl=%b prs=%b want 000001/000001",
               Key_Level, Key_Press);
    end
    step(1);
    n_cmp++;
    if (Key_Level !== 6'b000001 || Key_Press !== 6'b0) begin
      n_bad++;
      $display("FAIL press_after: lvl=%b prs=%b want 000001/0",
               Key_Level, Key_Press);
    end
    Key_Raw[0] = 1'b1;
    step(25);
    n_cmp++;
    if (Key_Level !== 6'b0) begin
      n_bad++;
      $display("FAIL press_undo: lvl=%b want 0", Key_Level);
    end
  endtask

  task automatic test_bounce();
    int lows[4]  = '{5, 8, 0, 0};
    int highs[2] = '{3, 2};
    bit early;
    early = 1'b0;
    for (int k = 0; k < 2; k++) begin
      Key_Raw[2] = 1'b0;
      for (int i = 0; i < lows[k]; i++) begin
        step(1);
        if (Key_Press[2] !== 1'b0 || Key_Level[2] !== 1'b0) early = 1'b1;
      end
      Key_Raw[2] = 1'b1;
      for (int i = 0; i < highs[k]; i++) begin
        step(1);
        if (Key_Press[2] !== 1'b0 || Key_Level[2] !== 1'b0) early = 1'b1;
      end
    end
    Key_Raw[2] = 1'b0;
    for (int i = 0; i < 17; i++) begin
      step(1);
      if (Key_Press[2] !== 1'b0 || Key_Level[2] !== 1'b0) early = 1'b1;
    end
    n_cmp++;
    if (early) begin
      n_bad++;
      $display("FAIL bounce_early: pulse/level before window, want none");
    end
    step(1);
    n_cmp++;
    if (Key_Press !== 6'b000100 || Key_Level !== 6'b000100) begin
      n_bad++;
      $display("FAIL bounce_edge: prs=%b lvl=%b want 000100/000100",
               Key_Press, Key_Level);
    end
    step(1);
    n_cmp++;
    if (Key_Press !== 6'b0) begin
      n_bad++;
      $display("FAIL bounce_once: prs=%b want 0", Key_Press);
    end
    Key_Raw[2] = 1'b1;
    step(25);
  endtask

  task automatic test_release();
    Key_Raw[3] = 1'b0;
    step(20);
    n_cmp++;
    if (Key_Level !== 6'b001000) begin
      n_bad++;
      $display("FAIL rel_setup: lvl=%b want 001000", Key_Level);
    end
    Key_Raw[3] = 1'b1;
    step(17);
    n_cmp++;
    if (Key_Level !== 6'b001000 || Key_Release !== 6'b0) begin
      n_bad++;
      $display("FAIL rel_early: lvl=%b rel=%b want 001000/0",
               Key_Level, Key_Release);
    end
    step(1);
    n_cmp++;
    if (Key_Level !== 6'b0 || Key_Press !== 6'b0 ||
        Key_Release !== (REL_EN ? 6'b001000 : 6'b0)) begin
      n_bad++;
      $display("FAIL rel_edge: lvl=%b prs=%b rel=%b want 0/0/%b",
               Key_Level, Key_Press, Key_Release,
               REL_EN ? 6'b001000 : 6'b0);
    end
    step(1);
    n_cmp++;
    if (Key_Release !== 6'b0) begin
      n_bad++;
      $display("FAIL rel_after: rel=%b want 0", Key_Release);
    end
  endtask

  task automatic test_simultaneous();
    Key_Raw[1] = 1'b0;
    Key_Raw[4] = 1'b0;
    step(18);
    n_cmp++;
    if (Key_Press !== 6'b010010 || Key_Level !== 6'b010010) begin
      n_bad++;
      $display("FAIL simul_edge: prs=%b lvl=%b want 010010/010010",
               Key_Press, Key_Level);
    end
    step(1);
    n_cmp++;
    if (Key_Press !== 6'b0) begin
      n_bad++;
      $display("FAIL simul_after: prs=%b want 0", Key_Press);
    end
    Key_Raw[1] = 1'b1;
    Key_Raw[4] = 1'b1;
    step(25);
    n_cmp++;
    if (Key_Level !== 6'b0) begin
      n_bad++;
      $display("FAIL simul_undo: lvl=%b want 0", Key_Level);
    end
  endtask

  task automatic test_reset_mid();
    Key_Raw[0] = 1'b0;
    step(20);
    Key_Raw[5] = 1'b0;
    // Channel 5 reaches cnt=10 after its 12th edge.
    step(12);
    n_cmp++;
    if (Key_Level !== 6'b000001) begin
      n_bad++;
      $display("FAIL mid_setup: lvl=%b want 000001", Key_Level);
    end
    RSTn = 1'b0;
    #1;
    n_cmp++;
    if ({Key_Level, Key_Press, Key_Release} !== 18'd0) begin
      n_bad++;
      $display("FAIL mid_clear: got %b/%b/%b want 0",
               Key_Level, Key_Press, Key_Release);
    end
    step(3);
    RSTn = 1'b1;
    step(17);
    n_cmp++;
    if (Key_Level !== 6'b0 || Key_Press !== 6'b0) begin
      n_bad++;
      $display("FAIL mid_early: lvl=%b prs=%b want 0/0",
               Key_Level, Key_Press);
    end
    step(1);
    n_cmp++;
    if (Key_Level !== 6'b100001 || Key_Press !== 6'b100001) begin
      n_bad++;
      $display("FAIL mid_repress: lvl=%b prs=%b want 100001/100001",
               Key_Level, Key_Press);
    end
    Key_Raw = 6'b111111;
    step(25);
    n_cmp++;
    if (Key_Level !== 6'b0) begin
      n_bad++;
      $display("FAIL mid_undo: lvl=%b want 0", Key_Level);
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
